// File: rtl/logar_pkg.sv
// Shared definitions for the iterative floor(log2) unit: FSM encoding and
// result-width helper.
package logar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int out_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/logar_2_iter.sv
// Iterative floor(log2) of an unsigned operand by binary search over shift
// amounts, with valid/ready handshakes on both sides; one operand in flight.
module logar_2_iter
  import logar_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int OUT_W = out_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_base,
  output logic             out_zero,
  output logic             out_pow2
);

  localparam logic [OUT_W-1:0] STEP_INIT = OUT_W'(WIDTH / 2);
  localparam logic [OUT_W-1:0] STEP_LAST = OUT_W'(1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] shifted;
  logic [OUT_W-1:0] base;
  logic [OUT_W-1:0] step;
  logic             zero;
  logic             pow2;

  assign shifted = work >> step;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_base  = '0;
    out_zero  = 1'b0;
    out_pow2  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (in_num == '0) ? DONE : SEARCH;
      end
      SEARCH: begin
        if (step == STEP_LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_base  = base;
        out_zero  = zero;
        out_pow2  = pow2;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Steps are distinct powers of two, so base only ever gains disjoint bits
  // and stays within WIDTH-1 without carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      base <= '0;
      step <= '0;
      zero <= 1'b0;
      pow2 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_num;
            base <= '0;
            step <= STEP_INIT;
            zero <= (in_num == '0);
            pow2 <= (in_num != '0) && ((in_num & (in_num - WIDTH'(1))) == '0);
          end
        end
        SEARCH: begin
          if (shifted != '0) begin
            base <= base + step;
            work <= shifted;
          end
          step <= step >> 1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logar_2_iter.sv
// Bench for logar_2_iter: a WIDTH=32 and a WIDTH=8 instance, a transaction
// level reference model checked every cycle, and directed literal checks.
module tb_logar_2_iter;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic        a_out_zero, a_out_pow2;
  logic [31:0] a_in_num;
  logic [4:0]  a_out_base;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic        b_out_zero, b_out_pow2;
  logic [7:0]  b_in_num;
  logic [2:0]  b_out_base;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logar_2_iter #(.WIDTH(32)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_num(a_in_num),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_base(a_out_base), .out_zero(a_out_zero), .out_pow2(a_out_pow2)
  );

  logar_2_iter #(.WIDTH(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_num(b_in_num),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_base(b_out_base), .out_zero(b_out_zero), .out_pow2(b_out_pow2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int flog2(input logic [31:0] v);
    int r = 0;
    for (int b = 0; b < 32; b++) if (v[b]) r = b;
    return r;
  endfunction

  function automatic int popcnt(input logic [31:0] v);
    int c = 0;
    for (int b = 0; b < 32; b++) if (v[b]) c++;
    return c;
  endfunction

  bit          m_pend [2] = '{0, 0};
  int          m_age  [2];
  int          m_lat  [2];
  int          m_base [2];
  bit          m_zero [2];
  bit          m_pow2 [2];
  bit          s_iv   [2];
  bit          s_ord  [2];
  logic [31:0] s_num  [2];
  int          outw   [2] = '{5, 3};

  // Pending operand is visible once m_age (edges counted from accept,
  // accept edge = 1) reaches the latency; it retires on a ready edge.
  always @(posedge clk) begin
    s_iv[0] = a_in_valid;  s_ord[0] = a_out_ready;  s_num[0] = a_in_num;
    s_iv[1] = b_in_valid;  s_ord[1] = b_out_ready;  s_num[1] = {24'd0, b_in_num};
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pend[i] = 1'b0;
      end else if (m_pend[i]) begin
        if (m_age[i] >= m_lat[i] && s_ord[i]) m_pend[i] = 1'b0;
        else if (m_age[i] < m_lat[i])         m_age[i]++;
      end else if (s_iv[i]) begin
        m_pend[i] = 1'b1;
        m_age[i]  = 1;
        m_zero[i] = (s_num[i] == 0);
        m_base[i] = m_zero[i] ? 0 : flog2(s_num[i]);
        m_pow2[i] = (popcnt(s_num[i]) == 1);
        m_lat[i]  = m_zero[i] ? 1 : outw[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = m_pend[0] && (m_age[0] >= m_lat[0]);
    check("w32 in_ready",  32'(a_in_ready),  32'(!m_pend[0]));
    check("w32 out_valid", 32'(a_out_valid), 32'(ev));
    check("w32 out_base",  32'(a_out_base),  ev ? m_base[0] : 0);
    check("w32 out_zero",  32'(a_out_zero),  ev ? 32'(m_zero[0]) : 0);
    check("w32 out_pow2",  32'(a_out_pow2),  ev ? 32'(m_pow2[0]) : 0);
    ev = m_pend[1] && (m_age[1] >= m_lat[1]);
    check("w8 in_ready",  32'(b_in_ready),  32'(!m_pend[1]));
    check("w8 out_valid", 32'(b_out_valid), 32'(ev));
    check("w8 out_base",  32'(b_out_base),  ev ? m_base[1] : 0);
    check("w8 out_zero",  32'(b_out_zero),  ev ? 32'(m_zero[1]) : 0);
    check("w8 out_pow2",  32'(b_out_pow2),  ev ? 32'(m_pow2[1]) : 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input int i, input bit v, input logic [31:0] n);
    if (i == 0) begin a_in_valid = v; a_in_num = n; end
    else begin b_in_valid = v; b_in_num = n[7:0]; end
  endtask

  task automatic set_ordy(input int i, input bit v);
    if (i == 0) a_out_ready = v;
    else        b_out_ready = v;
  endtask

  function automatic bit get_valid(input int i);
    return (i == 0) ? a_out_valid : b_out_valid;
  endfunction
  function automatic bit get_ready(input int i);
    return (i == 0) ? a_in_ready : b_in_ready;
  endfunction
  function automatic int get_base(input int i);
    return (i == 0) ? int'(a_out_base) : int'(b_out_base);
  endfunction
  function automatic bit get_zero(input int i);
    return (i == 0) ? a_out_zero : b_out_zero;
  endfunction
  function automatic bit get_pow2(input int i);
    return (i == 0) ? a_out_pow2 : b_out_pow2;
  endfunction

  // Offer one operand (instance must be idle), measure latency in edges
  // counting the accept edge, check the literal result, optionally stall.
  task automatic run_op(input int i, input logic [31:0] n, input int e_base,
                        input bit e_zero, input bit e_pow2, input int e_lat,
                        input int hold);
    int edges;
    bit seen;
    set_ordy(i, hold == 0);
    set_in(i, 1'b1, n);
    @(posedge clk); #1;
    set_in(i, 1'b0, 32'd0);
    edges = 1;
    seen  = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (get_valid(i)) seen = 1'b1;
      else begin @(posedge clk); #1; edges++; end
    end
    if (!seen) begin
      check("op timeout", 32'd0, 32'd1);
    end else begin
      check("op latency", 32'(edges),         32'(e_lat));
      check("op base",    32'(get_base(i)),   32'(e_base));
      check("op zero",    32'(get_zero(i)),   32'(e_zero));
      check("op pow2",    32'(get_pow2(i)),   32'(e_pow2));
    end
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        set_in(i, k[0], 32'h0000_0055);
      end
      @(negedge clk);
      check("stall base",     32'(get_base(i)),  32'(e_base));
      check("stall valid",    32'(get_valid(i)), 32'd1);
      check("stall in_ready", 32'(get_ready(i)), 32'd0);
      set_in(i, 1'b0, 32'd0);
      set_ordy(i, 1'b1);
    end
    @(posedge clk); #1;
    set_ordy(i, 1'b0);
    @(negedge clk);
    check("retire in_ready",  32'(get_ready(i)), 32'd1);
    check("retire out_valid", 32'(get_valid(i)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(0, 1'b0, 32'd0);  set_in(1, 1'b0, 32'd0);
    set_ordy(0, 1'b0);       set_ordy(1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready",  32'(a_in_ready),  32'd1);
    check("reset out_valid", 32'(a_out_valid), 32'd0);
    check("reset out_base",  32'(a_out_base),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // WIDTH=32: first op is offered on the first edge with rst low
    run_op(0, 32'h0000_0001,  0, 1'b0, 1'b1, 6, 0);
    run_op(0, 32'h8000_0000, 31, 1'b0, 1'b1, 6, 0);
    run_op(0, 32'h0000_0600, 10, 1'b0, 1'b0, 6, 0);
    run_op(0, 32'h0000_0000,  0, 1'b1, 1'b0, 1, 0);
    run_op(0, 32'h0001_2345, 16, 1'b0, 1'b0, 6, 10);

    // reset in the middle of SEARCH discards the operand
    set_in(0, 1'b1, 32'd7);
    @(posedge clk); #1;
    set_in(0, 1'b0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst in_ready",  32'(a_in_ready),  32'd1);
    check("rst out_valid", 32'(a_out_valid), 32'd0);
    check("rst out_base",  32'(a_out_base),  32'd0);
    check("rst out_pow2",  32'(a_out_pow2),  32'd0);
    check("rst out_zero",  32'(a_out_zero),  32'd0);
    run_op(0, 32'd7, 2, 1'b0, 1'b0, 6, 0);

    // WIDTH=8
    run_op(1, 32'd2,   1, 1'b0, 1'b1, 4, 0);
    run_op(1, 32'd128, 7, 1'b0, 1'b1, 4, 0);
    run_op(1, 32'hFF,  7, 1'b0, 1'b0, 4, 0);
    run_op(1, 32'd0,   0, 1'b1, 1'b0, 1, 3);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logar_2_iter.md
LOGAR_2_ITER -- requirements
Module: logar_2_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, input word width; must be a power of two, >= 2.
REQ-002 SHALL derive localparam OUT_W, equal to $clog2(WIDTH), the result width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  in_num is offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port in_num  input  WIDTH  operand, unsigned.
REQ-008 SHALL have port out_valid  output  1  result is presented.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port out_base  output  OUT_W  floor(log2(in_num)).
REQ-011 SHALL have port out_zero  output  1  operand was 0; out_base is 0.
REQ-012 SHALL have port out_pow2  output  1  operand was an exact nonzero power of two.

Function
REQ-013 SHALL implement a 3-state FSM with states IDLE, SEARCH and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL define accept as a rising edge with in_valid & in_ready; in_num is sampled only at accept.
REQ-016 SHALL, at accept, latch the following: work=in_num; base=0; step=WIDTH/2; zero=(in_num==0); pow2=(in_num!=0)&&((in_num&(in_num-1))==0).
REQ-017 SHALL, at accept, go from IDLE to DONE if in_num==0, otherwise to SEARCH.
REQ-018 SHALL, on each SEARCH edge where (work>>step)!=0, set base+=step and work>>=step; step>>=1 on every SEARCH edge.
REQ-019 SHALL spend exactly OUT_W edges in SEARCH, the last with step==1, and then go to DONE.
REQ-020 SHALL have a latency from accept edge to out_valid high of OUT_W+1 edges for nonzero operands and 1 edge for zero operands.
REQ-021 SHALL hold out_base, out_zero and out_pow2 stable in DONE until out_valid & out_ready, then go to IDLE.
REQ-022 SHALL permit one operand in flight at most; in_valid outside IDLE is ignored and no state changes.
REQ-023 SHALL not allow out_ready to return to IDLE and accept in the same edge; the next accept is no earlier than the edge after the handshake.
REQ-024 SHALL have no combinational path from in_* to out_*, or from out_ready to in_ready.
REQ-025 SHALL drive out_base, out_zero and out_pow2 as 0 outside DONE.
REQ-026 SHALL ensure base never exceeds WIDTH-1 and that no internal arithmetic overflows OUT_W bits.

Reset
REQ-027 SHALL, on rst high at an edge, enter IDLE with work, base, step and the flags cleared: in_ready=1, out_valid=0, and all result outputs 0.
REQ-028 SHALL have rst take priority over any handshake in the same edge; an operand in SEARCH or DONE is discarded and no result is presented.
REQ-029 SHALL have the first accept possible on the first edge with rst low.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE, SEARCH, DONE) in a shared package, logar_pkg, with the function computing OUT_W from WIDTH.
REQ-031 SHALL be implemented as a single module; no sub-module is required.
REQ-032 SHALL leave the original combinational one-hot logar_2 unchanged; logar_2_iter is its parametrised, handshaked successor with no one-hot restriction.

Verification
REQ-033 SHALL cover, with WIDTH=32: in_num=1, out_ready=1 -> out_base=0, out_pow2=1, out_zero=0, and out_valid exactly 6 edges after accept.
REQ-034 SHALL cover, with WIDTH=32: in_num=32'h8000_0000 -> out_base=31, out_pow2=1; and in_num=32'h0000_0600 -> out_base=10, out_pow2=0.
REQ-035 SHALL cover, with WIDTH=32: in_num=0 -> out_zero=1, out_base=0, out_pow2=0, and out_valid 1 edge after accept.
REQ-036 SHALL cover out_ready held low 10 cycles in DONE -> outputs stable and in_ready=0 throughout, with in_valid pulses ignored; the result retires on the first edge with out_ready high.
REQ-037 SHALL cover rst pulsed during SEARCH -> IDLE with all outputs 0 on the next edge; a new operand 7 then yields out_base=2.
REQ-038 SHALL cover, with WIDTH=8: in_num=2 -> 1 and in_num=128 -> 7, each with out_pow2=1 and latency 4, plus in_num=8'hFF -> 7 with out_pow2=0.
